// File: rtl/cskip_sub32_seq.sv
// Sequential borrow-skip subtractor: diff = a - b - bin, one BLK-bit block per clock.
// Optional ovf/zero flag outputs are enabled by defining CSKIP_SUB_FLAGS_EN.
module cskip_sub32_seq #(
  parameter int WIDTH = 32,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef CSKIP_SUB_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero
`endif
);

  localparam int NBLK = WIDTH / BLK;
  localparam int KW   = (NBLK > 1) ? $clog2(NBLK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             brw;
  logic [KW-1:0]    k;

  logic [BLK-1:0]   a_blk;
  logic [BLK-1:0]   b_blk;
  logic [BLK:0]     sub;
  logic             ripple;
  logic             blk_eq;
  logic             next_brw;
  logic [WIDTH-1:0] diff_full;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // One block per cycle; equal nibbles pass the incoming borrow along the skip path.
  always_comb begin
    a_blk     = a_r[BLK*k +: BLK];
    b_blk     = b_r[BLK*k +: BLK];
    sub       = {1'b0, a_blk} - {1'b0, b_blk} - {{BLK{1'b0}}, brw};
    ripple    = sub[BLK];
    blk_eq    = (a_blk == b_blk);
    next_brw  = blk_eq ? brw : ripple;
    diff_full = diff;
    diff_full[BLK*k +: BLK] = sub[BLK-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      brw   <= 1'b0;
      k     <= '0;
      diff  <= '0;
      bout  <= 1'b0;
`ifdef CSKIP_SUB_FLAGS_EN
      ovf   <= 1'b0;
      zero  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            brw   <= bin;
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          diff <= diff_full;
          brw  <= next_brw;
          if (k == KW'(NBLK-1)) begin
            bout  <= next_brw;
`ifdef CSKIP_SUB_FLAGS_EN
            ovf   <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff_full[WIDTH-1] != a_r[WIDTH-1]);
            zero  <= (diff_full == '0);
`endif
            state <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cskip_sub32_seq.sv
// Randomized self-checking bench for cskip_sub32_seq against a plain-arithmetic model.
// Flag checks are compiled in when CSKIP_SUB_FLAGS_EN is defined.
module tb_cskip_sub32_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        bout;
`ifdef CSKIP_SUB_FLAGS_EN
  logic        ovf;
  logic        zero;
`endif

  int total = 0;
  int bad   = 0;

  cskip_sub32_seq #(.WIDTH(32), .BLK(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .bin(bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff(diff),
    .bout(bout)
`ifdef CSKIP_SUB_FLAGS_EN
    ,
    .ovf(ovf),
    .zero(zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One full transaction: accept, 8 RUN cycles, optional DONE backpressure, release.
  task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb_in, input logic tbin,
                               input int hold, input bit pulse);
    logic [32:0] wide;
    logic [31:0] exp_diff;
    logic        exp_b;
    longint      sd;
    logic        exp_ovf;
    int          wait_cnt;
    wide     = {1'b0, ta} - {1'b0, tb_in} - {32'b0, tbin};
    exp_diff = wide[31:0];
    exp_b    = wide[32];
    sd       = longint'($signed(ta)) - longint'($signed(tb_in)) - longint'({31'b0, tbin});
    exp_ovf  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);

    wait_cnt = 0;
    while (!in_ready && wait_cnt < 20) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    checkOutput("idle_ready", 32'(in_ready), 32'd1);

    a = ta; b = tb_in; bin = tbin; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (pulse && i >= 2 && i <= 4) begin
        in_valid = 1'b1;
        a = $urandom;
        b = $urandom;
        bin = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checkOutput($sformatf("out_valid_c%0d", i), 32'(out_valid), (i == 8) ? 32'd1 : 32'd0);
      if (i < 8) checkOutput("in_ready_run", 32'(in_ready), 32'd0);
    end
    checkOutput("diff", diff, exp_diff);
    checkOutput("bout", 32'(bout), 32'(exp_b));
`ifdef CSKIP_SUB_FLAGS_EN
    checkOutput("ovf", 32'(ovf), 32'(exp_ovf));
    checkOutput("zero", 32'(zero), 32'(exp_diff == 32'd0));
`endif

    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_ready", 32'(in_ready), 32'd0);
      checkOutput("hold_diff", diff, exp_diff);
      checkOutput("hold_bout", 32'(bout), 32'(exp_b));
    end

    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("release_valid", 32'(out_valid), 32'd0);
    checkOutput("release_ready", 32'(in_ready), 32'd1);
    checkOutput("idle_diff_kept", diff, exp_diff);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] m;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    #23;
    checkOutput("rst_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_diff", diff, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(32'h0000_0005, 32'h0000_0003, 1'b0, 0, 1'b0);
    applyStimulus(32'h0000_0000, 32'h0000_0001, 1'b0, 0, 1'b0);
    applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b0, 0, 1'b0);
    applyStimulus(32'h1234_5678, 32'h1234_5678, 1'b1, 0, 1'b0);
    applyStimulus(32'h1234_5678, 32'h1234_5678, 1'b0, 0, 1'b0);
    applyStimulus(32'hA5A5_0000, 32'h3C3C_FFFF, 1'b1, 5, 1'b1);

    // Reset in the middle of RUN discards the operation.
    a = 32'hDEAD_BEEF; b = 32'h0000_1111; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_diff", diff, 32'd0);
    checkOutput("midrst_bout", 32'(bout), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("postrst_valid", 32'(out_valid), 32'd0);
    applyStimulus(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1, 1'b0);

    for (int t = 0; t < 24; t++) begin
      ra = $urandom;
      m  = '0;
      for (int j = 0; j < 8; j++) if ($urandom_range(0, 1) == 1) m[j*4 +: 4] = 4'hF;
      rb = (t % 3 == 0) ? $urandom : ((ra & m) | ($urandom & ~m));
      applyStimulus(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
